// File: rtl/apuf_pkg.sv
// apuf_pkg: shared state type, default parameters and majority helper
// for the arbiter PUF blocks.
package apuf_pkg;
    typedef enum logic [2:0] {IDLE, APPLY, RISE, SAMPLE, FALL, DONE} apuf_state_t;
    localparam int APUF_CH_W = 32;
    localparam int APUF_SETTLE = 8;
    localparam int APUF_VOTES = 5;
    function automatic logic apuf_majority(input int ones, input int votes);
        return ones > votes / 2;
    endfunction
endpackage

// File: rtl/apuf_if.sv
// apuf_if: challenge request and voted response handshakes between a host
// and the PUF sequencer.
interface apuf_if import apuf_pkg::*; #(
    parameter int CH_W = APUF_CH_W,
    parameter int VOTES = APUF_VOTES
) ();
    localparam int CONF_W = $clog2(VOTES + 1);
    logic req_valid;
    logic req_ready;
    logic [CH_W-1:0] req_challenge;
    logic rsp_valid;
    logic rsp_ready;
    logic rsp_bit;
    logic [CONF_W-1:0] rsp_conf;
    modport master (
        output req_valid, req_challenge, rsp_ready,
        input req_ready, rsp_valid, rsp_bit, rsp_conf
    );
    modport slave (
        input req_valid, req_challenge, rsp_ready,
        output req_ready, rsp_valid, rsp_bit, rsp_conf
    );
endinterface

// File: rtl/apuf_sync2.sv
// apuf_sync2: two-flop synchronizer, both stages reset to 0.
module apuf_sync2 (
    input logic clk,
    input logic rst_n,
    input logic d,
    output logic q
);
    logic m;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) {q, m} <= 2'b00;
        else {q, m} <= {m, d};
    end
endmodule

// File: rtl/apuf_ctrl.sv
// apuf_ctrl: sequences an arbiter PUF race VOTES times per challenge and
// returns the majority-voted bit with the count of races that returned 1.
module apuf_ctrl import apuf_pkg::*; #(
    parameter int CH_W = APUF_CH_W,
    parameter int SETTLE = APUF_SETTLE,
    parameter int VOTES = APUF_VOTES
) (
    input logic clk,
    input logic rst_n,
    apuf_if.slave bus,
    output logic [CH_W-1:0] puf_challenge,
    output logic puf_launch,
    input logic puf_resp,
    output logic busy
);
    localparam int CW = $clog2(SETTLE + 1);
    localparam int VW = $clog2(VOTES + 1);
    if (VOTES < 1 || VOTES % 2 == 0 || SETTLE < 3) begin : g_bad_param
        $fatal(1, "apuf_ctrl: VOTES must be odd and >= 1, SETTLE must be >= 3");
    end
    apuf_state_t state;
    logic [CW-1:0] cnt;
    logic [VW-1:0] vidx;
    logic [VW-1:0] ones;
    logic resp_s;
    apuf_sync2 u_sync (.clk(clk), .rst_n(rst_n), .d(puf_resp), .q(resp_s));
    // rsp_valid follows DONE by one cycle so the response fields are settled first
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt <= '0;
            vidx <= '0;
            ones <= '0;
            puf_challenge <= '0;
            puf_launch <= 1'b0;
            busy <= 1'b0;
            bus.req_ready <= 1'b0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_bit <= 1'b0;
            bus.rsp_conf <= '0;
        end else begin
            case (state)
                IDLE: begin
                    bus.req_ready <= 1'b1;
                    if (bus.req_valid && bus.req_ready) begin
                        puf_challenge <= bus.req_challenge;
                        ones <= '0;
                        vidx <= '0;
                        cnt <= CW'(SETTLE - 1);
                        busy <= 1'b1;
                        bus.req_ready <= 1'b0;
                        state <= APPLY;
                    end
                end
                APPLY: begin
                    cnt <= (cnt == 0) ? CW'(SETTLE - 1) : cnt - 1'b1;
                    puf_launch <= (cnt == 0);
                    if (cnt == 0) state <= RISE;
                end
                RISE: begin
                    cnt <= cnt - 1'b1;
                    if (cnt == 0) state <= SAMPLE;
                end
                SAMPLE: begin
                    ones <= ones + VW'(resp_s);
                    cnt <= CW'(SETTLE - 1);
                    puf_launch <= 1'b0;
                    state <= FALL;
                end
                FALL: begin
                    if (cnt != 0) cnt <= cnt - 1'b1;
                    else begin
                        vidx <= vidx + 1'b1;
                        cnt <= CW'(SETTLE - 1);
                        puf_launch <= (vidx != VW'(VOTES - 1));
                        state <= (vidx == VW'(VOTES - 1)) ? DONE : RISE;
                    end
                end
                DONE: begin
                    bus.rsp_bit <= apuf_majority(int'(ones), VOTES);
                    bus.rsp_conf <= ones;
                    bus.rsp_valid <= !(bus.rsp_valid && bus.rsp_ready);
                    if (bus.rsp_valid && bus.rsp_ready) begin
                        busy <= 1'b0;
                        bus.req_ready <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_apuf_ctrl.sv
// tb_apuf_ctrl: scoreboard bench for apuf_ctrl at default parameters and at
// VOTES=1/SETTLE=3, including launch waveform, back-pressure and abort by reset.
module tb_apuf_ctrl;
    import apuf_pkg::*;
    typedef struct {logic b; int conf; int lat;} exp_t;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [31:0] pc0, pc1;
    logic pl0, pl1, busy0, busy1;
    logic pr0 = 1'b0;
    logic pr1 = 1'b0;
    exp_t sb[$];
    int n_cmp = 0;
    int n_bad = 0;
    apuf_if #(.CH_W(32), .VOTES(5)) b0 ();
    apuf_if #(.CH_W(32), .VOTES(1)) b1 ();
    apuf_ctrl #(.CH_W(32), .SETTLE(8), .VOTES(5)) dut0 (
        .clk(clk), .rst_n(rst_n), .bus(b0), .puf_challenge(pc0),
        .puf_launch(pl0), .puf_resp(pr0), .busy(busy0)
    );
    apuf_ctrl #(.CH_W(32), .SETTLE(3), .VOTES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .bus(b1), .puf_challenge(pc1),
        .puf_launch(pl1), .puf_resp(pr1), .busy(busy1)
    );
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One request on the default-parameter DUT; pat[i] is the arbiter result of race i+1.
    task automatic run0(input logic [31:0] ch, input logic [4:0] pat, input int hold, input int abort_race);
        int ones, race, bad, kr, unstable, k;
        logic prev, exp_l;
        exp_t e;
        ones = $countones(pat);
        race = 0; bad = 0; kr = 0; unstable = 0; prev = 1'b0;
        for (int i = 0; i < 200 && b0.req_ready !== 1'b1; i++) step();
        chk("req_ready_idle", b0.req_ready, 1);
        b0.req_challenge = ch;
        b0.req_valid = 1'b1;
        step();
        b0.req_valid = 1'b0;
        sb.push_back('{ones > 2, ones, 1 + 8 + 5 * 17});
        chk("challenge_latched", pc0, ch);
        chk("busy_after_accept", busy0, 1);
        chk("req_ready_after_accept", b0.req_ready, 0);
        for (k = 1; k < 2000; k++) begin
            step();
            exp_l = (k >= 8 && k < 93 && (k - 8) % 17 < 9);
            if (pl0 !== exp_l) bad++;
            if (pl0 === 1'b1 && !prev && race < 5) begin
                race++;
                pr0 = pat[race-1];
            end
            prev = pl0;
            if (abort_race != 0 && race == abort_race) begin
                kr++;
                if (kr == 3) begin
                    #3 rst_n = 1'b0;
                    #1;
                    chk("abort_launch", pl0, 0);
                    chk("abort_busy", busy0, 0);
                    chk("abort_rsp_valid", b0.rsp_valid, 0);
                    chk("abort_challenge", pc0, 0);
                    void'(sb.pop_back());
                    #10 rst_n = 1'b1;
                    return;
                end
            end
            if (b0.rsp_valid === 1'b1) break;
        end
        chk("launch_wave_errors", bad, 0);
        chk("race_count", race, 5);
        e = sb.pop_front();
        chk("latency", k, e.lat);
        chk("rsp_bit", b0.rsp_bit, e.b);
        chk("rsp_conf", b0.rsp_conf, e.conf);
        b0.req_challenge = ~ch;
        for (int i = 0; i < hold; i++) begin
            b0.req_valid = 1'b1;
            step();
            if (b0.rsp_bit !== e.b || b0.rsp_conf !== 3'(e.conf) || b0.rsp_valid !== 1'b1
                || b0.req_ready !== 1'b0 || pl0 !== 1'b0 || busy0 !== 1'b1) unstable++;
        end
        b0.req_valid = 1'b0;
        if (hold > 0) begin
            chk("hold_stable_errors", unstable, 0);
            chk("hold_no_accept", pc0, ch);
        end
        b0.rsp_ready = 1'b1;
        step();
        b0.rsp_ready = 1'b0;
        chk("req_ready_after_rsp", b0.req_ready, 1);
        chk("rsp_valid_cleared", b0.rsp_valid, 0);
        chk("busy_idle", busy0, 0);
    endtask

    // One request on the VOTES=1, SETTLE=3 DUT with the arbiter tied to r.
    task automatic run1(input logic r);
        int k;
        exp_t e;
        for (int i = 0; i < 200 && b1.req_ready !== 1'b1; i++) step();
        b1.req_challenge = 32'h1234_5678;
        b1.req_valid = 1'b1;
        pr1 = r;
        step();
        b1.req_valid = 1'b0;
        sb.push_back('{r, int'(r), 1 + 3 + 1 * 7});
        for (k = 1; k < 200; k++) begin
            step();
            if (b1.rsp_valid === 1'b1) break;
        end
        e = sb.pop_front();
        chk("v1_latency", k, e.lat);
        chk("v1_rsp_bit", b1.rsp_bit, e.b);
        chk("v1_rsp_conf", b1.rsp_conf, e.conf);
        b1.rsp_ready = 1'b1;
        step();
        b1.rsp_ready = 1'b0;
        chk("v1_req_ready_after_rsp", b1.req_ready, 1);
    endtask

    initial begin
        int seen;
        b0.req_valid = 1'b0; b0.rsp_ready = 1'b0; b0.req_challenge = '0;
        b1.req_valid = 1'b0; b1.rsp_ready = 1'b0; b1.req_challenge = '0;
        #12;
        chk("rst_req_ready", b0.req_ready, 0);
        chk("rst_challenge", pc0, 0);
        chk("rst_launch", pl0, 0);
        chk("rst_rsp_valid", b0.rsp_valid, 0);
        chk("rst_rsp_bit", b0.rsp_bit, 0);
        chk("rst_rsp_conf", b0.rsp_conf, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_v1_req_ready", b1.req_ready, 0);
        #10 rst_n = 1'b1;
        step();
        chk("req_ready_after_release", b0.req_ready, 1);
        run0(32'hA5A5_0F0F, 5'b11111, 0, 0);
        run0(32'h1357_9BDF, 5'b10101, 20, 0);
        run0(32'h0000_FFFF, 5'b01010, 0, 0);
        run0(32'hDEAD_BEEF, 5'b11111, 0, 3);
        seen = 0;
        for (int i = 0; i < 120; i++) begin
            step();
            if (b0.rsp_valid !== 1'b0) seen++;
        end
        chk("no_rsp_after_abort", seen, 0);
        chk("scoreboard_empty_after_abort", sb.size(), 0);
        run0(32'hCAFE_F00D, 5'b00100, 0, 0);
        run1(1'b1);
        run1(1'b0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/apuf_ctrl.md
# apuf_ctrl

Sequencer for the arbiter PUF delay chain. Takes a challenge from a valid/ready request port and drives it onto the mux-stage select lines. Launches the race pulse repeatedly and samples the arbiter output through a synchronizer on each race. Returns a majority-voted response bit with a confidence count. Sits between the host/test interface and the combinational PUF core (mux chain plus arbiter latch).

## Interface
Parameters:
- CH_W, 32: challenge width, one bit per mux stage pair.
- SETTLE, 8: cycles allowed for the chain to settle after each edge; must be ≥3 (covers the 2-flop sync).
- VOTES, 5: races per challenge; odd, ≥1.

Ports:
- clk  in  1  sole clock.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  challenge request.
- req_ready  out  1  high only in IDLE.
- req_challenge  in  CH_W  challenge, captured on accept.
- puf_challenge  out  CH_W  registered select lines to the mux stages.
- puf_launch  out  1  race pulse into both chain inputs, registered.
- puf_resp  in  1  arbiter output, asynchronous to clk.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_bit  out  1  majority result.
- rsp_conf  out  $clog2(VOTES+1)  number of races that returned 1.
- busy  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, APPLY, RISE, SAMPLE, FALL, DONE.
- IDLE: req_ready=1. On req_valid&&req_ready: latch req_challenge into puf_challenge, clear the ones counter and the vote index, go to APPLY.
- APPLY: puf_launch=0 for SETTLE cycles, then go to RISE.
- RISE: puf_launch=1 for SETTLE cycles, then go to SAMPLE.
- SAMPLE: one cycle, puf_launch stays 1. Add the synchronized puf_resp to the ones counter. Go to FALL.
- FALL: puf_launch=0 for SETTLE cycles. Then increment the vote index: if it equals VOTES go to DONE, else go to RISE.
- DONE: rsp_valid=1. rsp_conf=ones count. rsp_bit=(ones > VOTES/2). All three are held stable until rsp_ready. On rsp_valid&&rsp_ready go to IDLE.
- puf_challenge holds its value from accept until the next accept; it is not cleared in IDLE.
- puf_resp passes through a 2-flop synchronizer, always running, and is used only in SAMPLE.
- A single shared down-counter, width $clog2(SETTLE+1), times APPLY, RISE and FALL.

## Timing
- Reset values: req_ready=0 while rst_n is low, then 1 from the first cycle after release. puf_challenge=0, puf_launch=0, rsp_valid=0, rsp_bit=0, rsp_conf=0, busy=0. Synchronizer flops reset to 0.
- Reset asserted mid-operation: puf_launch drops immediately (asynchronously) and the FSM returns to IDLE. No response is produced for the aborted request.
- Latency: for an accept at edge T, rsp_valid first rises at edge T+1+SETTLE+VOTES×(2·SETTLE+1). With defaults that is T+94.
- Minimum spacing: the next req_ready rises 1 cycle after the rsp handshake.
- req_valid in any non-IDLE state is ignored; req_ready=0 there.
- rsp_ready held low: the block stays in DONE indefinitely with outputs unchanged, and puf_launch stays 0.
- Counter wrap: the ones counter is never wider than needed, since its maximum value is VOTES.

## Structure
- Package apuf_pkg holds:
  - the state enum apuf_state_t;
  - default constants APUF_CH_W, APUF_SETTLE, APUF_VOTES;
  - the function apuf_majority(ones, votes).
- Elaboration check: VOTES odd and SETTLE≥3, else a fatal error.
- One sub-module: apuf_sync2, a 2-flop synchronizer with reset to 0. It is reused by other PUF blocks.

## Test plan
- Defaults, puf_resp tied to 1, challenge 0xA5A5_0F0F: puf_challenge=0xA5A5_0F0F one cycle after accept; rsp_valid at T+94; rsp_bit=1, rsp_conf=5.
- puf_resp driven 1 during races 1, 3, 5 and 0 otherwise: rsp_bit=1, rsp_conf=3. Drive 1 only in races 2, 4: rsp_bit=0, rsp_conf=2.
- puf_launch waveform: exactly 5 high pulses, each 9 cycles wide, separated by 8 low cycles, and preceded by 8 low cycles after accept.
- rsp_ready low for 20 cycles after rsp_valid: rsp_bit/rsp_conf stable, req_ready=0, a new req_valid is not accepted. Then rsp_ready=1: req_ready=1 on the next cycle.
- rst_n pulsed low during the third RISE: puf_launch=0 and busy=0 immediately; rsp_valid never rises; after release a fresh request completes normally.
- VOTES=1, SETTLE=3: rsp_valid at T+11; rsp_conf equals the single sample.
